// File: rtl/rps_classify_ctrl_if.sv
// Row stream in, classification result out, plus busy status.
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid && ready are both high; the producer holds data stable while
// valid is high and ready is low.
interface rps_classify_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             row_valid;
   logic             row_ready;
   logic [WIDTH-1:0] row_data;
   logic             busy;
   logic             result_valid;
   logic             result_ready;
   logic [1:0]       result;
   logic [15:0]      sum;
   logic [15:0]      sum_left;
   logic [5:0]       leftmost;
   logic [5:0]       num_transitions;

   // Front end / consumer side
   modport master (
      output row_valid, row_data, result_ready,
      input  row_ready, busy, result_valid, result, sum, sum_left,
             leftmost, num_transitions
   );

   // Classifier sequencer side
   modport slave (
      input  row_valid, row_data, result_ready,
      output row_ready, busy, result_valid, result, sum, sum_left,
             leftmost, num_transitions
   );
endinterface

// File: rtl/rps_classify_ctrl.sv
// Row-serial rock-paper-scissors classifier sequencer: buffers one binarized
// frame, computes its features over two passes, and offers a gesture result.
module rps_classify_ctrl #(
   parameter int LENGTH = 32,
   parameter int WIDTH  = 32,
   parameter int LEFT   = 8,
   parameter int SHIFT  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rps_classify_ctrl_if.slave   bus,
   output logic [2:0]           dbg_state_o
);

   typedef enum logic [2:0] {
      S_LOAD   = 3'd0,
      S_PASS1  = 3'd1,
      S_PASS2  = 3'd2,
      S_DECIDE = 3'd3,
      S_HOLD   = 3'd4
   } state_t;

   localparam int              RW      = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam logic [RW-1:0]   LAST    = RW'(LENGTH - 1);
   localparam logic [RW-1:0]   LAST2   = RW'(LENGTH - 2);
   localparam logic [6:0]      WIDTH_C = 7'(WIDTH);
   localparam logic [15:0]     THRESH  = 16'((LENGTH * WIDTH) / 50);

   state_t            state_q;
   logic [RW-1:0]     row_cnt_q;
   logic [WIDTH-1:0]  buf_q [LENGTH];
   logic              row_ready_q;
   logic              busy_q;
   logic              result_valid_q;
   logic [1:0]        result_q;
   logic [15:0]       sum_q;
   logic [15:0]       sum_left_q;
   logic [5:0]        leftmost_q;
   logic [5:0]        num_trans_q;

   logic [RW-1:0]     nxt_idx_d;
   logic [WIDTH-1:0]  row_cur_d;
   logic [WIDTH-1:0]  row_nxt_d;
   logic [WIDTH-1:0]  diff_d;
   logic [15:0]       pop_all_d;
   logic [15:0]       pop_left_d;
   logic [5:0]        low_idx_d;
   logic              low_found_d;
   logic [6:0]        col_d;
   logic              trans_hit_d;

   // Count lit bits among columns 0..n-1
   function automatic logic [15:0] count_bits(input logic [WIDTH-1:0] v, input int n);
      logic [15:0] c;
      c = '0;
      for (int j = 0; j < WIDTH; j++) begin
         if (j < n && v[j]) c = c + 16'd1;
      end
      return c;
   endfunction

   // Per-row feature terms for the row currently addressed by row_cnt_q
   always_comb begin
      nxt_idx_d   = (row_cnt_q == LAST) ? '0 : row_cnt_q + RW'(1);
      row_cur_d   = buf_q[row_cnt_q];
      row_nxt_d   = buf_q[nxt_idx_d];
      pop_all_d   = count_bits(row_cur_d, WIDTH);
      pop_left_d  = count_bits(row_cur_d, LEFT);
      low_idx_d   = 6'(WIDTH);
      for (int j = WIDTH - 1; j >= 0; j--) begin
         if (row_cur_d[j]) low_idx_d = 6'(j);
      end
      low_found_d = |row_cur_d;
      // Probe column can land past the right edge; then it never counts
      col_d       = 7'(leftmost_q) + 7'(SHIFT);
      diff_d      = (row_cur_d ^ row_nxt_d) >> col_d;
      trans_hit_d = (col_d < WIDTH_C) && diff_d[0];
   end

   // Sequencer FSM with registered outputs and the frame buffer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= S_LOAD;
         row_cnt_q      <= '0;
         row_ready_q    <= 1'b1;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
         result_q       <= 2'd0;
         sum_q          <= '0;
         sum_left_q     <= '0;
         leftmost_q     <= 6'(WIDTH);
         num_trans_q    <= '0;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (bus.row_valid && row_ready_q) begin
                  buf_q[row_cnt_q] <= bus.row_data;
                  if (row_cnt_q == LAST) begin
                     row_cnt_q   <= '0;
                     sum_q       <= '0;
                     sum_left_q  <= '0;
                     num_trans_q <= '0;
                     leftmost_q  <= 6'(WIDTH);
                     row_ready_q <= 1'b0;
                     busy_q      <= 1'b1;
                     state_q     <= S_PASS1;
                  end else begin
                     row_cnt_q <= row_cnt_q + RW'(1);
                  end
               end
            end
            S_PASS1: begin
               sum_q      <= sum_q + pop_all_d;
               sum_left_q <= sum_left_q + pop_left_d;
               if (low_found_d && (low_idx_d < leftmost_q)) leftmost_q <= low_idx_d;
               if (row_cnt_q == LAST) begin
                  row_cnt_q <= '0;
                  state_q   <= S_PASS2;
               end else begin
                  row_cnt_q <= row_cnt_q + RW'(1);
               end
            end
            S_PASS2: begin
               if (trans_hit_d) num_trans_q <= num_trans_q + 6'd1;
               if (row_cnt_q == LAST2) begin
                  row_cnt_q <= '0;
                  state_q   <= S_DECIDE;
               end else begin
                  row_cnt_q <= row_cnt_q + RW'(1);
               end
            end
            S_DECIDE: begin
               if (num_trans_q == 6'd4)      result_q <= 2'd2;
               else if (sum_left_q > THRESH) result_q <= 2'd1;
               else                          result_q <= 2'd0;
               result_valid_q <= 1'b1;
               busy_q         <= 1'b0;
               state_q        <= S_HOLD;
            end
            S_HOLD: begin
               if (bus.result_ready) begin
                  result_valid_q <= 1'b0;
                  row_ready_q    <= 1'b1;
                  state_q        <= S_LOAD;
               end
            end
            default: state_q <= S_LOAD;
         endcase
      end
   end

   assign bus.row_ready       = row_ready_q;
   assign bus.busy            = busy_q;
   assign bus.result_valid    = result_valid_q;
   assign bus.result          = result_q;
   assign bus.sum             = sum_q;
   assign bus.sum_left        = sum_left_q;
   assign bus.leftmost        = leftmost_q;
   assign bus.num_transitions = num_trans_q;
   assign dbg_state_o         = state_q;

endmodule
